// File: rtl/xalu_mdu.sv
// rtl/xalu_mdu.sv - multi-cycle multiply/divide unit owning the HI/LO register pair
module xalu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic             hilo,
    input  logic             outsel,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;

    // Result is computed combinationally from the captured operands and held
    // stable for the whole count; only the commit is delayed.
    logic               sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] ma, mb, prod;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    always_comb begin
        sgn    = op_q[0];
        a_neg  = sgn & a_q[WIDTH-1];
        b_neg  = sgn & b_q[WIDTH-1];
        ma     = {{WIDTH{a_neg}}, a_q};
        mb     = {{WIDTH{b_neg}}, b_q};
        prod   = ma * mb;
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (state_q == IDLE) begin
            if (!cancel) begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else if (we) begin
                    if (hilo) hi_d = a;
                    else      lo_d = a;
                end
            end
        end else begin
            if (cancel) begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (!op_q[1]) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (b_q != '0) begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = outsel ? hi_q : lo_q;
endmodule
